// File: rtl/hv_bundle_ctrl.sv
// Majority-bundling controller for hypervectors: accumulates per-lane one-counts
// over cfg_num input vectors, then emits the strict-majority vector.
module hv_bundle_ctrl #(
   parameter int W  = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] cfg_num,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_THRESH, S_OUT} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   num_q, num_d;
   logic [DW-1:0]   vec_q, vec_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [DW-1:0]   cnt_q [W];
   logic [DW-1:0]   cnt_d [W];
   logic            clr, en;

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      vec_d      = vec_q;
      out_data_d = out_data_q;
      clr        = 1'b0;
      en         = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         vec_d   = '0;
         clr     = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               num_d   = cfg_num;
               vec_d   = '0;
               clr     = 1'b1;
               state_d = (cfg_num != '0) ? S_ACC : S_THRESH;
            end
            S_ACC: if (in_valid) begin
               en    = 1'b1;
               vec_d = vec_q + 1'b1;
               if (vec_q == num_q - 1'b1) state_d = S_THRESH;
            end
            S_THRESH: begin
               // Strict majority at DW+1 bits: a tie (2*cnt == num) resolves to 0.
               for (int i = 0; i < W; i++)
                  out_data_d[i] = ({cnt_q[i], 1'b0} > {1'b0, num_q});
               state_d = S_OUT;
            end
            S_OUT: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < W; i++)
         cnt_d[i] = clr ? '0 : (en ? cnt_q[i] + DW'(in_data[i]) : cnt_q[i]);
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         vec_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         vec_q      <= vec_d;
         out_data_q <= out_data_d;
      end
   end

   // NOTE: the lane counters are plain flops, not a RAM, so resetting the whole array is legal and cheap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < W; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign in_ready  = (state_q == S_ACC);
   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_hv_bundle_ctrl.sv
// Scoreboard bench for hv_bundle_ctrl (W=4, DW=4): the driver pushes expected
// results with their due cycle, a monitor pops and compares on out_valid.
module tb_hv_bundle_ctrl;

   localparam int W  = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort;
   logic [DW-1:0] cfg_num;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_data;
   logic          busy;

   hv_bundle_ctrl #(.W(W), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_num   (cfg_num),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: first cycle of out_valid pops the scoreboard; later cycles check hold.
   initial begin
      logic         prev_valid;
      logic [W-1:0] held;
      exp_t         e;
      prev_valid = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (!prev_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("out_data", 32'(out_data), 32'(e.data));
                  check("out_latency", cyc, e.cyc);
               end
               held = out_data;
            end else begin
               check("out_stable", 32'(out_data), 32'(held));
            end
         end
         prev_valid = rst_n && out_valid;
      end
   end

   task automatic do_start(input logic [DW-1:0] n, output int s);
      @(posedge clk); #1;
      start   = 1'b1;
      cfg_num = n;
      s       = cyc;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] v, input bit last, input logic [W-1:0] exp);
      bit got;
      exp_t e;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_timeout", 32'(got), 32'd1);
      if (got && last) begin
         e.data = exp;
         e.cyc  = cyc + 2;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   s;
      int   acc;
      bit   seen;
      exp_t e;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Three-vector majority
      do_start(4'd3, s);
      feed(4'b1011, 1'b0, '0);
      feed(4'b0011, 1'b0, '0);
      feed(4'b1110, 1'b1, 4'b1011);
      wait_idle();

      // Two vectors, tie on lane 1 resolves to 0
      do_start(4'd2, s);
      feed(4'b0001, 1'b0, '0);
      feed(4'b0011, 1'b1, 4'b0001);
      wait_idle();

      // cfg_num = 0: no accepts, zero result two cycles after start
      do_start(4'd0, s);
      e.data = 4'b0000;
      e.cyc  = s + 2;
      sb.push_back(e);
      in_valid = 1'b1;
      in_data  = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         check("zero_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();

      // cfg_num = 15 with random in_valid gaps; extra offered vectors must not be taken
      do_start(4'd15, s);
      acc = 0;
      in_data = 4'b1111;
      for (int k = 0; k < 400 && acc < 15; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc++;
            if (acc == 15) begin
               e.data = 4'b1111;
               e.cyc  = cyc + 2;
               sb.push_back(e);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (in_valid && in_ready) acc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("accept_count_15", acc, 15);
      wait_idle();

      // Back-pressure in OUT with ignored start pulses
      out_ready = 1'b0;
      do_start(4'd1, s);
      feed(4'b1000, 1'b1, 4'b1000);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("out_valid_timeout", 32'(seen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         start   = k[0];
         cfg_num = 4'd3;
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_busy",      32'(busy),      32'd1);
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_busy",      32'(busy),      32'd0);
      repeat (2) begin
         @(negedge clk);
         check("start_not_queued", 32'(busy), 32'd0);
      end

      // Abort after two of three inputs, abort beats start, then a clean job
      do_start(4'd3, s);
      feed(4'b1111, 1'b0, '0);
      feed(4'b1111, 1'b0, '0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      abort   = 1'b1;
      start   = 1'b1;
      cfg_num = 4'd5;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("abort_over_start", 32'(busy), 32'd0);
      do_start(4'd1, s);
      feed(4'b0100, 1'b1, 4'b0100);
      wait_idle();

      // Reset pulse mid-ACC discards the job
      do_start(4'd3, s);
      feed(4'b1111, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_out_data",  32'(out_data),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_idle", 32'(busy), 32'd0);
      end
      do_start(4'd2, s);
      feed(4'b0011, 1'b0, '0);
      feed(4'b0010, 1'b1, 4'b0010);
      wait_idle();

      repeat (2) @(posedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
